load_store_unit: RTL

- Sits directly upstream of the 256 x 16-bit data memory, between the execute stage and the memory port.
- Accepts one load/store request at a time over a valid/ready handshake and computes the effective word address.
- Drives registered, glitch-free address, write-enable and write-data into the memory, which writes combinationally.
- Performs read-modify-write for byte stores, returns load data over a valid/ready response channel, and sequences the one-cycle memory dump strobe.

---
 rtl/load_store_unit.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Load/store front end for a 256 x 16-bit data memory.
//                Accepts one request at a time (valid/ready), forms the
//                effective word address base[7:0] + offset (mod 256), and
//                drives registered address / write-enable / write-data into
//                the memory. Byte stores are done as read-modify-write.
//                Load results return on a valid/ready response channel.
//                Also sequences the one-cycle memory dump strobe.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n        clock (rising edge), asynchronous active-low reset
//    req_valid/ready   request handshake
//    req_we            1 = store, 0 = load
//    req_byte, req_hi  byte access, byte select (1 = [15:8])
//    req_sext          byte loads: sign-extend when set
//    req_base          base register (only [ADDR_W-1:0] used)
//    req_offset        two's-complement word offset
//    req_wdata         store data (byte stores use [7:0])
//    req_tag           destination tag echoed with the load response
//    resp_valid/ready  response handshake; resp_data / resp_tag payload
//    mem_addr          memory word address (registered)
//    mem_wr_en         memory write enable (registered, one cycle per store)
//    mem_wr_data       memory write data (registered)
//    mem_rd_data       combinational read data of mem_addr
//    dump_req          memory dump request (level or pulse)
//    print_en          dump strobe to memory (registered, one cycle)
//    busy              access in progress or dump pending
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    // request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic              req_hi,
    input  logic              req_sext,
    input  logic [DATA_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    // response channel
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    // memory port
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    // dump control
    input  logic              dump_req,
    output logic              print_en,
    output logic              busy
);

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_WR   = 2'd2,
        S_DUMP = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_we;
    logic                r_byte;
    logic                r_hi;
    logic                r_sext;
    logic [TAG_W-1:0]    r_tag;
    logic [BYTE_W-1:0]   r_wbyte;
    logic                r_dump_pend;
    // Low during reset and for the first cycle after it, so that every
    // output (req_ready included) reads 0 while reset is asserted.
    logic                r_alive;

    logic [ADDR_W-1:0]   w_ea;
    logic                w_accept;
    logic [BYTE_W-1:0]   w_sel_byte;
    logic [DATA_W-1:0]   w_load_val;
    logic [DATA_W-1:0]   w_merge;
    logic                w_unused;

    // Effective address wraps silently inside the 256-word space.
    assign w_ea      = req_base[ADDR_W-1:0] + req_offset;
    assign w_unused  = ^req_base[DATA_W-1:ADDR_W];

    // Only one load may be outstanding: hold off requests while a response
    // is waiting to be taken.
    assign req_ready = r_alive && (r_state == S_IDLE) && !resp_valid;
    assign w_accept  = req_valid && req_ready;
    assign busy      = (r_state != S_IDLE) || r_dump_pend;

    // Load formatting and byte-store merge both work on the word the memory
    // is presenting during the ACC cycle.
    always_comb begin
        w_sel_byte = r_hi ? mem_rd_data[2*BYTE_W-1:BYTE_W] : mem_rd_data[BYTE_W-1:0];

        if (!r_byte) begin
            w_load_val = mem_rd_data;
        end else if (r_sext) begin
            w_load_val = {{(DATA_W-BYTE_W){w_sel_byte[BYTE_W-1]}}, w_sel_byte};
        end else begin
            w_load_val = {{(DATA_W-BYTE_W){1'b0}}, w_sel_byte};
        end

        if (r_hi) begin
            w_merge = {r_wbyte, mem_rd_data[BYTE_W-1:0]};
        end else begin
            w_merge = {mem_rd_data[2*BYTE_W-1:BYTE_W], r_wbyte};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_byte      <= 1'b0;
            r_hi        <= 1'b0;
            r_sext      <= 1'b0;
            r_tag       <= '0;
            r_wbyte     <= '0;
            r_dump_pend <= 1'b0;
            r_alive     <= 1'b0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_tag    <= '0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            print_en    <= 1'b0;
        end else begin
            r_alive <= 1'b1;

            // Any number of dump requests collapse into one pending dump; a
            // new request arriving during the DUMP cycle itself re-arms it.
            if (dump_req) begin
                r_dump_pend <= 1'b1;
            end else if (r_state == S_DUMP) begin
                r_dump_pend <= 1'b0;
            end

            if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    // A new request takes priority over a pending dump.
                    if (w_accept) begin
                        r_we     <= req_we;
                        r_byte   <= req_byte;
                        r_hi     <= req_hi;
                        r_sext   <= req_sext;
                        r_tag    <= req_tag;
                        r_wbyte  <= req_wdata[BYTE_W-1:0];
                        mem_addr <= w_ea;
                        // Word stores write in the ACC cycle itself, so the
                        // enable and data are loaded together with the address.
                        if (req_we && !req_byte) begin
                            mem_wr_en   <= 1'b1;
                            mem_wr_data <= req_wdata;
                        end
                        r_state <= S_ACC;
                    end else if (r_dump_pend) begin
                        print_en <= 1'b1;
                        r_state  <= S_DUMP;
                    end
                end

                S_ACC: begin
                    mem_wr_en <= 1'b0;
                    if (!r_we) begin
                        resp_valid <= 1'b1;
                        resp_data  <= w_load_val;
                        resp_tag   <= r_tag;
                        r_state    <= S_IDLE;
                    end else if (r_byte) begin
                        // Read half of the RMW: the merged word becomes the
                        // write data for the following WR cycle.
                        mem_wr_en   <= 1'b1;
                        mem_wr_data <= w_merge;
                        r_state     <= S_WR;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_WR: begin
                    mem_wr_en <= 1'b0;
                    r_state   <= S_IDLE;
                end

                S_DUMP: begin
                    print_en <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: begin
                    mem_wr_en <= 1'b0;
                    print_en  <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
